// File: rtl/ofs_plat_avalon_mem_rd_credit_gate.sv
// Avalon-MM read-request credit gate: admits a burst only when its beats fit in the downstream
// response buffer. Optional statistics are enabled by defining OFS_PLAT_AVALON_RD_CREDIT_STATS_EN.
module ofs_plat_avalon_mem_rd_credit_gate #(
  parameter int ADDR_WIDTH            = 64,
  parameter int DATA_WIDTH            = 512,
  parameter int BURST_CNT_WIDTH       = 4,
  parameter int USER_WIDTH            = 1,
  parameter int MAX_OUTSTANDING_BEATS = 8,
  parameter int CNT_W                 = $clog2(MAX_OUTSTANDING_BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic                       src_rd_read,
  input  logic [ADDR_WIDTH-1:0]      src_rd_address,
  input  logic [BURST_CNT_WIDTH-1:0] src_rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]    src_rd_byteenable,
  input  logic [USER_WIDTH-1:0]      src_rd_user,
  output logic                       src_rd_waitrequest,
  output logic [DATA_WIDTH-1:0]      src_rd_readdata,
  output logic                       src_rd_readdatavalid,
  output logic [USER_WIDTH-1:0]      src_rd_readresponseuser,

  output logic                       snk_rd_read,
  output logic [ADDR_WIDTH-1:0]      snk_rd_address,
  output logic [BURST_CNT_WIDTH-1:0] snk_rd_burstcount,
  output logic [DATA_WIDTH/8-1:0]    snk_rd_byteenable,
  output logic [USER_WIDTH-1:0]      snk_rd_user,
  input  logic                       snk_rd_waitrequest,
  input  logic [DATA_WIDTH-1:0]      snk_rd_readdata,
  input  logic                       snk_rd_readdatavalid,
  input  logic [USER_WIDTH-1:0]      snk_rd_readresponseuser,

  output logic [CNT_W-1:0]           outstanding_beats,
  output logic                       idle,
  output logic [31:0]                stat_stall_cycles,
  output logic [CNT_W-1:0]           stat_peak_beats
);

  // Sums are formed wide enough that count + burstcount can never wrap.
  localparam int SUM_W = ((CNT_W > BURST_CNT_WIDTH) ? CNT_W : BURST_CNT_WIDTH) + 1;
  localparam logic [SUM_W-1:0] MAX_BEATS = SUM_W'(MAX_OUTSTANDING_BEATS);

  if (MAX_OUTSTANDING_BEATS < 2 ** (BURST_CNT_WIDTH - 1)) begin : g_bad_capacity
    $error("MAX_OUTSTANDING_BEATS must be >= the largest legal burst");
  end

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [SUM_W-1:0] count_ext;
  logic [SUM_W-1:0] burst_ext;
  logic [SUM_W-1:0] sum_req;
  logic [SUM_W-1:0] sum_acc;
  logic [SUM_W-1:0] sum_next;
  logic             fits;
  logic             accept;
  logic             ret;

  assign count_ext = SUM_W'(count);
  assign burst_ext = SUM_W'(src_rd_burstcount);
  assign sum_req   = count_ext + burst_ext;
  // Registered count only: credit returned this cycle is usable next cycle.
  assign fits      = (sum_req <= MAX_BEATS);

  assign snk_rd_read        = src_rd_read & fits & reset_n;
  assign snk_rd_address     = src_rd_address;
  assign snk_rd_burstcount  = src_rd_burstcount;
  assign snk_rd_byteenable  = src_rd_byteenable;
  assign snk_rd_user        = src_rd_user;
  assign src_rd_waitrequest = snk_rd_waitrequest | ~fits | ~reset_n;

  assign src_rd_readdata         = snk_rd_readdata;
  assign src_rd_readdatavalid    = snk_rd_readdatavalid;
  assign src_rd_readresponseuser = snk_rd_readresponseuser;

  assign accept     = snk_rd_read & ~snk_rd_waitrequest;
  assign ret        = snk_rd_readdatavalid;
  assign sum_acc    = accept ? sum_req : count_ext;
  // Returns with nothing outstanding (e.g. stale beats from before a reset) saturate at zero.
  assign sum_next   = (ret && (sum_acc != '0)) ? (sum_acc - SUM_W'(1)) : sum_acc;
  assign count_next = CNT_W'(sum_next);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign outstanding_beats = count;
  assign idle              = (count == '0);

`ifdef OFS_PLAT_AVALON_RD_CREDIT_STATS_EN
  logic [31:0]      stall_q;
  logic [CNT_W-1:0] peak_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else begin
      if (src_rd_read && !fits && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (count_next > peak_q) begin
        peak_q <= count_next;
      end
    end
  end

  assign stat_stall_cycles = stall_q;
  assign stat_peak_beats   = peak_q;
`else
  assign stat_stall_cycles = '0;
  assign stat_peak_beats   = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && ret && (sum_acc == '0)) begin
      $error("read response returned with no outstanding beats");
    end
    if (reset_n && src_rd_read && ((src_rd_burstcount == '0) || (burst_ext > MAX_BEATS))) begin
      $error("illegal read burstcount %0d", src_rd_burstcount);
    end
  end
`endif

endmodule
